// File: rtl/spi_flash_responder.sv
// Serial-NOR-flash lookalike: answers READ (0x03) and JEDEC-ID (0x9F) from a
// byte-wide memory port, oversampling the mode-0 SPI pins in the clock domain.
`timescale 1ns/1ps
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter int unsigned MEM_AW   = 24
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              spi_csn,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_valid,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned RX_W  = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_IGNORE
    } state_e;

    logic [1:0] csn_s_q, sclk_s_q, mosi_s_q;
    logic       csn_d_q, sclk_d_q;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RX_W-1:0]     rx_q, rx_d;
    logic [7:0]          tx_q, tx_d;
    logic [2:0]          tx_cnt_q, tx_cnt_d;
    logic [1:0]          id_idx_q, id_idx_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [7:0]          hold_q, hold_d;
    logic                hold_vld_q, hold_vld_d;
    logic                drop_q, drop_d;
    logic                mem_valid_q, mem_valid_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic                miso_q, miso_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                underrun_q, underrun_d;

    logic       csn_fall, csn_rise, sclk_rise, sclk_fall, mosi_bit;
    logic [7:0] cmd_c, byte_c;
    logic [23:0] addr_c;

    // Two-flop synchronizers plus one edge-detect stage per pin
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csn_s_q  <= 2'b11;
            csn_d_q  <= 1'b1;
            sclk_s_q <= 2'b00;
            sclk_d_q <= 1'b0;
            mosi_s_q <= 2'b00;
        end else begin
            csn_s_q  <= {csn_s_q[0], spi_csn};
            csn_d_q  <= csn_s_q[1];
            sclk_s_q <= {sclk_s_q[0], spi_sclk};
            sclk_d_q <= sclk_s_q[1];
            mosi_s_q <= {mosi_s_q[0], spi_mosi};
        end
    end

    assign csn_fall  =  csn_d_q  & ~csn_s_q[1];
    assign csn_rise  = ~csn_d_q  &  csn_s_q[1];
    assign sclk_rise = ~sclk_d_q &  sclk_s_q[1];
    assign sclk_fall =  sclk_d_q & ~sclk_s_q[1];
    assign mosi_bit  =  mosi_s_q[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            tx_cnt_q    <= '0;
            id_idx_q    <= '0;
            addr_q      <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            drop_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            tx_cnt_q    <= tx_cnt_d;
            id_idx_q    <= id_idx_d;
            addr_q      <= addr_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            drop_q      <= drop_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        tx_cnt_d    = tx_cnt_q;
        id_idx_d    = id_idx_q;
        addr_d      = addr_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        drop_d      = drop_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        miso_d      = miso_q;
        underrun_d  = underrun_q;
        busy_d      = ~csn_s_q[1];
        cmd_c       = {rx_q[6:0], mosi_bit};
        addr_c      = {rx_q, mosi_bit};
        byte_c      = 8'h00;

        // Fetch completion fills the holding register unless it belongs to an aborted transaction
        if (mem_valid_q && mem_ready) begin
            mem_valid_d = 1'b0;
            drop_d      = 1'b0;
            if (state_q == ST_DATA && !drop_q) begin
                hold_d     = mem_rdata;
                hold_vld_d = 1'b1;
                addr_d     = addr_q + MEM_AW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    rx_d      = {rx_q[RX_W-2:0], mosi_bit};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        tx_cnt_d  = '0;
                        id_idx_d  = '0;
                        case (cmd_c)
                            8'h03:   state_d = ST_ADDR;
                            8'h9F:   state_d = ST_ID;
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
            end
            ST_ADDR: begin
                if (sclk_rise) begin
                    rx_d      = {rx_q[RX_W-2:0], mosi_bit};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(23)) begin
                        state_d     = ST_DATA;
                        tx_cnt_d    = '0;
                        hold_vld_d  = 1'b0;
                        addr_d      = MEM_AW'(addr_c);
                        mem_addr_d  = MEM_AW'(addr_c);
                        mem_valid_d = 1'b1;
                    end
                end
            end
            ST_DATA, ST_ID: begin
                if (sclk_fall) begin
                    tx_cnt_d = tx_cnt_q + 3'd1;
                    if (tx_cnt_q == 3'd0) begin
                        // Byte boundary: pick the next byte, prefetch behind it in DATA
                        if (state_q == ST_ID) begin
                            case (id_idx_q)
                                2'd0:    byte_c = JEDEC_ID[23:16];
                                2'd1:    byte_c = JEDEC_ID[15:8];
                                2'd2:    byte_c = JEDEC_ID[7:0];
                                default: byte_c = 8'h00;
                            endcase
                            if (id_idx_q != 2'd3) begin
                                id_idx_d = id_idx_q + 2'd1;
                            end
                        end else if (hold_vld_q) begin
                            byte_c      = hold_q;
                            hold_vld_d  = 1'b0;
                            mem_valid_d = 1'b1;
                            mem_addr_d  = addr_q;
                        end else begin
                            byte_c     = 8'hFF;
                            underrun_d = 1'b1;
                        end
                        miso_d = byte_c[7];
                        tx_d   = {byte_c[6:0], 1'b0};
                    end else begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase

        // End of transaction wins over everything; a fetch still in flight is marked for discard
        if (csn_rise) begin
            state_d    = ST_IDLE;
            hold_vld_d = 1'b0;
            miso_d     = 1'b0;
            drop_d     = mem_valid_d;
        end

        oe_d = (state_d == ST_DATA) || (state_d == ST_ID);
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master at clock/8 plus a
// latency-programmable byte memory returning addr[7:0].
`timescale 1ns/1ps
module tb_spi_flash_responder;

    logic        clock;
    logic        reset_n;
    logic        spi_csn;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        mem_valid;
    logic [23:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        underrun;

    int          checks;
    int          failures;
    int          mem_lat;
    int          wait_cnt;
    logic        valid_prev;
    logic        oe_any;
    logic [23:0] fetch_log[$];
    int          log_base;
    logic [7:0]  rx;

    spi_flash_responder #(
        .JEDEC_ID(24'hEF4016),
        .MEM_AW  (24)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .spi_csn    (spi_csn),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .underrun   (underrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Memory: answers mem_lat negedges after request, logs every issued address
    initial begin
        mem_ready  = 1'b0;
        mem_rdata  = 8'h00;
        wait_cnt   = 0;
        valid_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_valid && !valid_prev) fetch_log.push_back(mem_addr);
            valid_prev = mem_valid;
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_valid) begin
                if (wait_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_addr[7:0];
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rxb);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            clk_n(4);
            spi_sclk = 1'b1;
            rxb[i]   = spi_miso;
            oe_any   = oe_any | spi_miso_oe;
            clk_n(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic start_cs();
        oe_any  = 1'b0;
        spi_csn = 1'b0;
        clk_n(4);
    endtask

    task automatic end_cs(input string tag);
        clk_n(4);
        spi_csn = 1'b1;
        clk_n(8);
        for (int k = 0; k < 100 && mem_valid; k++) clk_n(1);
        chk(tag, {31'd0, mem_valid}, 32'd0);
    endtask

    task automatic send_read(input logic [23:0] a);
        logic [7:0] d;
        xfer(8'h03, d);
        xfer(a[23:16], d);
        xfer(a[15:8], d);
        xfer(a[7:0], d);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mem_lat  = 2;
        oe_any   = 1'b0;
        reset_n  = 1'b0;
        spi_csn  = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        clk_n(3);
        chk("rst_miso",  {31'd0, spi_miso},    32'd0);
        chk("rst_oe",    {31'd0, spi_miso_oe}, 32'd0);
        chk("rst_valid", {31'd0, mem_valid},   32'd0);
        chk("rst_addr",  {8'd0, mem_addr},     32'd0);
        chk("rst_busy",  {31'd0, busy},        32'd0);
        chk("rst_under", {31'd0, underrun},    32'd0);
        reset_n = 1'b1;
        clk_n(4);

        // READ at 0x000000, four bytes
        log_base = fetch_log.size();
        start_cs();
        chk("read0_busy", {31'd0, busy}, 32'd1);
        send_read(24'h000000);
        for (int b = 0; b < 4; b++) begin
            xfer(8'h00, rx);
            chk($sformatf("read0_byte%0d", b), {24'd0, rx}, b);
        end
        chk("read0_oe", {31'd0, spi_miso_oe}, 32'd1);
        end_cs("read0_idle");
        chk("read0_under", {31'd0, underrun}, 32'd0);
        chk("read0_addr0", {8'd0, fetch_log[log_base]}, 32'h000000);

        // JEDEC ID, no memory traffic
        log_base = fetch_log.size();
        start_cs();
        xfer(8'h9F, rx);
        xfer(8'h00, rx); chk("id_byte0", {24'd0, rx}, 32'hEF);
        xfer(8'h00, rx); chk("id_byte1", {24'd0, rx}, 32'h40);
        xfer(8'h00, rx); chk("id_byte2", {24'd0, rx}, 32'h16);
        xfer(8'h00, rx); chk("id_byte3", {24'd0, rx}, 32'h00);
        chk("id_oe", {31'd0, spi_miso_oe}, 32'd1);
        end_cs("id_idle");
        chk("id_no_fetch", fetch_log.size() - log_base, 32'd0);

        // Address wrap from 0xFFFFFF
        log_base = fetch_log.size();
        start_cs();
        send_read(24'hFFFFFF);
        xfer(8'h00, rx); chk("wrap_byte0", {24'd0, rx}, 32'hFF);
        xfer(8'h00, rx); chk("wrap_byte1", {24'd0, rx}, 32'h00);
        end_cs("wrap_idle");
        chk("wrap_nfetch_ge3", {31'd0, fetch_log.size() - log_base >= 3}, 32'd1);
        if (fetch_log.size() - log_base >= 3) begin
            chk("wrap_addr0", {8'd0, fetch_log[log_base]},     32'hFFFFFF);
            chk("wrap_addr1", {8'd0, fetch_log[log_base + 1]}, 32'h000000);
            chk("wrap_addr2", {8'd0, fetch_log[log_base + 2]}, 32'h000001);
        end

        // Unknown command: output never enabled
        start_cs();
        xfer(8'h05, rx);
        xfer(8'h00, rx);
        xfer(8'h00, rx);
        chk("unk_busy", {31'd0, busy}, 32'd1);
        chk("unk_oe_any", {31'd0, oe_any}, 32'd0);
        end_cs("unk_idle");

        // Underrun with slow memory
        mem_lat = 40;
        start_cs();
        send_read(24'h000020);
        xfer(8'h00, rx); chk("under_byte0", {24'd0, rx}, 32'hFF);
        chk("under_set", {31'd0, underrun}, 32'd1);
        xfer(8'h00, rx); chk("under_byte1", {24'd0, rx}, 32'h20);
        end_cs("under_idle");
        chk("under_sticky", {31'd0, underrun}, 32'd1);

        // Abort in the middle of the address
        mem_lat = 2;
        start_cs();
        xfer(8'h03, rx);
        xfer(8'h00, rx);
        clk_n(2);
        spi_csn = 1'b1;
        clk_n(6);
        chk("abort_addr_oe",    {31'd0, spi_miso_oe}, 32'd0);
        chk("abort_addr_busy",  {31'd0, busy},        32'd0);
        chk("abort_addr_valid", {31'd0, mem_valid},   32'd0);
        clk_n(4);

        // Abort in DATA with a fetch still outstanding
        mem_lat = 40;
        start_cs();
        send_read(24'h000040);
        clk_n(2);
        chk("abort_data_oe_on", {31'd0, spi_miso_oe}, 32'd1);
        spi_csn = 1'b1;
        clk_n(5);
        chk("abort_data_oe_off", {31'd0, spi_miso_oe}, 32'd0);
        chk("abort_data_busy",   {31'd0, busy},        32'd0);
        chk("abort_data_valid_held", {31'd0, mem_valid}, 32'd1);
        chk("abort_data_addr_held",  {8'd0, mem_addr},   32'h000040);
        for (int k = 0; k < 100 && mem_valid; k++) clk_n(1);
        chk("abort_data_valid_drop", {31'd0, mem_valid}, 32'd0);
        clk_n(8);

        // Next READ after abort
        mem_lat = 2;
        start_cs();
        send_read(24'h000010);
        xfer(8'h00, rx); chk("post_abort_byte", {24'd0, rx}, 32'h10);
        xfer(8'h00, rx); chk("post_abort_byte2", {24'd0, rx}, 32'h11);
        end_cs("post_abort_idle");
        chk("post_abort_under", {31'd0, underrun}, 32'd1);

        // Asynchronous reset in the middle of a READ
        start_cs();
        send_read(24'h000010);
        xfer(8'h00, rx);
        clk_n(2);
        chk("prerst_oe",   {31'd0, spi_miso_oe}, 32'd1);
        chk("prerst_busy", {31'd0, busy},        32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_miso",  {31'd0, spi_miso},    32'd0);
        chk("arst_oe",    {31'd0, spi_miso_oe}, 32'd0);
        chk("arst_valid", {31'd0, mem_valid},   32'd0);
        chk("arst_addr",  {8'd0, mem_addr},     32'd0);
        chk("arst_busy",  {31'd0, busy},        32'd0);
        chk("arst_under", {31'd0, underrun},    32'd0);
        spi_csn = 1'b1;
        clk_n(3);
        reset_n = 1'b1;
        clk_n(6);
        chk("postrst_oe",    {31'd0, spi_miso_oe}, 32'd0);
        chk("postrst_busy",  {31'd0, busy},        32'd0);
        chk("postrst_under", {31'd0, underrun},    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
